// File: rtl/systolic_result_drain_if.sv
// Row stream between the systolic result drain and its downstream consumer.
interface systolic_result_drain_if #(
   parameter int unsigned N         = 4,
   parameter int unsigned ACC_WIDTH = 16
);
   localparam int unsigned ROW_BITS = N * ACC_WIDTH;

   logic                out_valid;
   logic                out_ready;
   logic [ROW_BITS-1:0] out_row;
   logic                out_last;

   modport master (output out_valid, output out_row, output out_last, input out_ready);
   modport slave  (input out_valid, input out_row, input out_last, output out_ready);
endinterface

// File: rtl/systolic_result_drain.sv
// Deskews the bottom-row partial-sum stream of the systolic array into whole
// result rows and buffers them in a small FIFO for a valid/ready consumer.
module systolic_result_drain #(
   parameter int unsigned N         = 4,
   parameter int unsigned ACC_WIDTH = 16,
   parameter int unsigned BASE_LAT  = 5,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned ROW_W     = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [ROW_W-1:0]       num_rows,
   input  logic [N*ACC_WIDTH-1:0] col_psum,
   systolic_result_drain_if.master out_if,
   output logic                   busy,
   output logic                   done,
   output logic                   overflow
);
   localparam int unsigned ROW_BITS  = N * ACC_WIDTH;
   localparam int unsigned PTR_W     = $clog2(DEPTH);
   localparam int unsigned CNT_W     = PTR_W + 1;
   localparam int unsigned WAIT_LOAD = BASE_LAT + N - 1;
   localparam int unsigned WAIT_W    = $clog2(WAIT_LOAD + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_DRAIN   = 2'd3;

   logic [ROW_BITS-1:0] aligned;

   // Column j is delayed N-1-j cycles so every element of a row lands together.
   for (genvar j = 0; j < N; j++) begin : g_col
      localparam int STAGES = int'(N) - 1 - j;
      if (STAGES == 0) begin : g_direct
         assign aligned[j*ACC_WIDTH +: ACC_WIDTH] = col_psum[j*ACC_WIDTH +: ACC_WIDTH];
      end else begin : g_line
         logic [ACC_WIDTH-1:0] line_q [STAGES];
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int k = 0; k < STAGES; k++) line_q[k] <= '0;
            end else begin
               line_q[0] <= col_psum[j*ACC_WIDTH +: ACC_WIDTH];
               for (int k = 1; k < STAGES; k++) line_q[k] <= line_q[k-1];
            end
         end
         assign aligned[j*ACC_WIDTH +: ACC_WIDTH] = line_q[STAGES-1];
      end
   end

   logic [1:0]          state_q, state_nxt;
   logic [WAIT_W-1:0]   wait_q, wait_nxt;
   logic [ROW_W-1:0]    row_q, row_nxt;
   logic [ROW_W-1:0]    rows_q, rows_nxt;
   logic                wr_en, wr_last, done_nxt, ovf_clr;

   logic [ROW_BITS-1:0] mem_row  [DEPTH];
   logic                mem_last [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
   logic [CNT_W-1:0]    count_q, count_nxt;
   logic [ROW_BITS-1:0] head_row_q;
   logic                head_last_q, valid_q;
   logic                busy_q, done_q, ovf_q;
   logic                pop, full, wr_accept, wr_drop;

   assign pop       = valid_q & out_if.out_ready;
   assign full      = (count_q == CNT_W'(DEPTH));
   assign wr_accept = wr_en & (~full | pop);
   assign wr_drop   = wr_en & full & ~pop;
   assign wr_last   = (row_q == rows_q - ROW_W'(1));

   always_comb begin
      rd_ptr_nxt = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_nxt  = count_q;
      if (wr_accept && !pop)      count_nxt = count_q + CNT_W'(1);
      else if (!wr_accept && pop) count_nxt = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
         row_q   <= '0;
         rows_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         wait_q  <= wait_nxt;
         row_q   <= row_nxt;
         rows_q  <= rows_nxt;
         busy_q  <= (state_nxt != S_IDLE);
         done_q  <= done_nxt;
         if (ovf_clr)      ovf_q <= 1'b0;
         else if (wr_drop) ovf_q <= 1'b1;
      end
   end

   // WAIT hands over to CAPTURE one edge early so the first write hits W_0.
   always_comb begin
      state_nxt = state_q;
      wait_nxt  = wait_q;
      row_nxt   = row_q;
      rows_nxt  = rows_q;
      wr_en     = 1'b0;
      done_nxt  = 1'b0;
      ovf_clr   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               ovf_clr  = 1'b1;
               rows_nxt = num_rows;
               row_nxt  = '0;
               if (num_rows == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  state_nxt = S_WAIT;
                  wait_nxt  = WAIT_W'(WAIT_LOAD);
               end
            end
         end
         S_WAIT: begin
            if (wait_q <= WAIT_W'(2)) state_nxt = S_CAPTURE;
            else                      wait_nxt  = wait_q - WAIT_W'(1);
         end
         S_CAPTURE: begin
            wr_en   = 1'b1;
            row_nxt = row_q + ROW_W'(1);
            if (wr_last) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (count_nxt == '0) begin
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // The head row is registered; a write into the next head slot bypasses memory.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            mem_row[k]  <= '0;
            mem_last[k] <= 1'b0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         head_row_q  <= '0;
         head_last_q <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         if (wr_accept) begin
            mem_row[wr_ptr_q]  <= aligned;
            mem_last[wr_ptr_q] <= wr_last;
            wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
         end
         rd_ptr_q <= rd_ptr_nxt;
         count_q  <= count_nxt;
         valid_q  <= (count_nxt != '0);
         if (wr_accept && (wr_ptr_q == rd_ptr_nxt)) begin
            head_row_q  <= aligned;
            head_last_q <= wr_last;
         end else begin
            head_row_q  <= mem_row[rd_ptr_nxt];
            head_last_q <= mem_last[rd_ptr_nxt];
         end
      end
   end

   assign out_if.out_valid = valid_q;
   assign out_if.out_row   = head_row_q;
   assign out_if.out_last  = head_last_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign overflow         = ovf_q;
endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: deskew timing, FIFO full/empty
// boundaries, overflow, done pulse and reset behaviour.
module tb_systolic_result_drain;
   localparam int unsigned N  = 4;
   localparam int unsigned AW = 16;
   localparam int LEN = 28;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  num_rows;
   logic [63:0] col_psum;
   logic        busy, done, overflow;

   systolic_result_drain_if #(.N(N), .ACC_WIDTH(AW)) sif ();

   systolic_result_drain #(
      .N(N), .ACC_WIDTH(AW), .BASE_LAT(5), .DEPTH(4), .ROW_W(8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .num_rows (num_rows),
      .col_psum (col_psum),
      .out_if   (sif),
      .busy     (busy),
      .done     (done),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] tbl [16][4];
   int          n_pop, done_cnt, done_edge, first_valid;
   logic [63:0] pop_row  [16];
   logic        pop_last [16];
   int          pop_edge [16];
   logic        busy0, ovf0, ovf_end, busy_end, rst_busy, rst_valid, any_last;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_linear(input logic [15:0] base);
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 4; j++)
            tbl[i][j] = base + 16'(16 * i + j);
   endtask

   // Element C[i][j] must sit on column j during the cycle before edge S+5+i+j.
   task automatic drive_cols(input int t, input int m);
      for (int j = 0; j < 4; j++) begin
         int i;
         i = t - 4 - j;
         if (i >= 0 && i < m) col_psum[j*16 +: 16] = tbl[i][j];
         else                 col_psum[j*16 +: 16] = 16'hDEAD;
      end
   endtask

   function automatic logic ready_at(input int mode, input int r, input int e);
      case (mode)
         0:       return 1'b1;
         1:       return e >= r;
         default: return (e == r) || (e >= r + 4);
      endcase
   endfunction

   task automatic run_job(input int m, input int mode, input int r,
                          input int busy_start_t, input int rst_edge);
      n_pop = 0; done_cnt = 0; done_edge = -1; first_valid = -1; any_last = 1'b0;
      rst_busy = 1'b1; rst_valid = 1'b1;
      start = 1'b1;
      num_rows = 8'(m);
      sif.out_ready = 1'b0;
      drive_cols(-1, m);
      step();
      for (int t = 0; t < LEN; t++) begin
         if (done) begin done_cnt++; done_edge = t; end
         if (sif.out_valid && first_valid < 0) first_valid = t;
         if (t == 0) begin busy0 = busy; ovf0 = overflow; end
         drive_cols(t, m);
         start = (t == busy_start_t);
         num_rows = start ? 8'd7 : 8'(m);
         sif.out_ready = ready_at(mode, r, t + 1);
         rst_n = !(t + 1 == rst_edge);
         if (sif.out_valid && sif.out_ready && rst_n && n_pop < 16) begin
            pop_row[n_pop]  = sif.out_row;
            pop_last[n_pop] = sif.out_last;
            pop_edge[n_pop] = t + 1;
            any_last        = any_last | sif.out_last;
            n_pop++;
         end
         step();
         if (t + 1 == rst_edge) begin rst_busy = busy; rst_valid = sif.out_valid; end
      end
      rst_n = 1'b1;
      start = 1'b0;
      sif.out_ready = 1'b0;
      ovf_end  = overflow;
      busy_end = busy;
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         start = 1'($urandom);
         num_rows = 8'($urandom);
         col_psum = {$urandom, $urandom};
         sif.out_ready = 1'($urandom);
         step();
      end
      check_val("rst_valid", 64'(sif.out_valid), 64'd0);
      check_val("rst_row",   sif.out_row,        64'd0);
      check_val("rst_last",  64'(sif.out_last),  64'd0);
      check_val("rst_busy",  64'(busy),          64'd0);
      check_val("rst_done",  64'(done),          64'd0);
      check_val("rst_ovf",   64'(overflow),      64'd0);
      rst_n = 1'b1; start = 1'b0; sif.out_ready = 1'b0;
      step(); step();

      // Single row
      fill_linear(16'd100);
      run_job(1, 0, 0, -1, -1);
      check_val("single_busy0",   64'(busy0),       64'd1);
      check_val("single_valid_t", 64'(first_valid), 64'd8);
      check_val("single_npop",    64'(n_pop),       64'd1);
      check_val("single_row",     pop_row[0],       64'h0067_0066_0065_0064);
      check_val("single_last",    64'(pop_last[0]), 64'd1);
      check_val("single_done_n",  64'(done_cnt),    64'd1);
      check_val("single_done_t",  64'(done_edge),   64'd9);
      check_val("single_busy_end", 64'(busy_end),   64'd0);

      // Streaming
      fill_linear(16'h0000);
      run_job(3, 0, 0, -1, -1);
      check_val("stream_npop",  64'(n_pop),       64'd3);
      check_val("stream_pop0t", 64'(pop_edge[0]), 64'd9);
      check_val("stream_row0",  pop_row[0],       64'h0003_0002_0001_0000);
      check_val("stream_row1",  pop_row[1],       64'h0013_0012_0011_0010);
      check_val("stream_row2",  pop_row[2],       64'h0023_0022_0021_0020);
      check_val("stream_last0", 64'(pop_last[0]), 64'd0);
      check_val("stream_last1", 64'(pop_last[1]), 64'd0);
      check_val("stream_last2", 64'(pop_last[2]), 64'd1);
      check_val("stream_ovf",   64'(ovf_end),     64'd0);
      check_val("stream_done_n", 64'(done_cnt),   64'd1);
      check_val("stream_done_t", 64'(done_edge),  64'd11);

      // Backpressure / overflow
      fill_linear(16'h0200);
      run_job(6, 1, 15, -1, -1);
      check_val("bp_npop",   64'(n_pop),       64'd4);
      check_val("bp_pop0t",  64'(pop_edge[0]), 64'd15);
      check_val("bp_row0",   pop_row[0],       64'h0203_0202_0201_0200);
      check_val("bp_row3",   pop_row[3],       64'h0233_0232_0231_0230);
      check_val("bp_nolast", 64'(any_last),    64'd0);
      check_val("bp_ovf",    64'(ovf_end),     64'd1);
      check_val("bp_done_n", 64'(done_cnt),    64'd1);
      check_val("bp_done_t", 64'(done_edge),   64'd18);

      // Full with simultaneous pop
      fill_linear(16'h0300);
      run_job(5, 2, 12, -1, -1);
      check_val("fp_ovf_clr", 64'(ovf0),        64'd0);
      check_val("fp_npop",    64'(n_pop),       64'd5);
      check_val("fp_pop0t",   64'(pop_edge[0]), 64'd12);
      check_val("fp_pop1t",   64'(pop_edge[1]), 64'd16);
      check_val("fp_row0",    pop_row[0],       64'h0303_0302_0301_0300);
      check_val("fp_row4",    pop_row[4],       64'h0343_0342_0341_0340);
      check_val("fp_last4",   64'(pop_last[4]), 64'd1);
      check_val("fp_ovf",     64'(ovf_end),     64'd0);
      check_val("fp_done_t",  64'(done_edge),   64'd19);

      // Signed pass-through with a start while busy
      for (int j = 0; j < 4; j++) begin
         tbl[0][j] = (j % 2 == 0) ? 16'hFFFF : 16'h8000;
         tbl[1][j] = (j % 2 == 0) ? 16'h8000 : 16'hFFFF;
      end
      run_job(2, 0, 0, 3, -1);
      check_val("sgn_npop",   64'(n_pop),       64'd2);
      check_val("sgn_row0",   pop_row[0],       64'h8000_FFFF_8000_FFFF);
      check_val("sgn_row1",   pop_row[1],       64'hFFFF_8000_FFFF_8000);
      check_val("sgn_last1",  64'(pop_last[1]), 64'd1);
      check_val("sgn_done_n", 64'(done_cnt),    64'd1);
      check_val("sgn_done_t", 64'(done_edge),   64'd10);

      // Zero-row job
      run_job(0, 0, 0, -1, -1);
      check_val("m0_done_t", 64'(done_edge),   64'd0);
      check_val("m0_done_n", 64'(done_cnt),    64'd1);
      check_val("m0_busy0",  64'(busy0),       64'd0);
      check_val("m0_valid",  64'(first_valid), 64'hFFFF_FFFF_FFFF_FFFF);
      check_val("m0_npop",   64'(n_pop),       64'd0);

      // Reset in the middle of CAPTURE
      fill_linear(16'h0400);
      run_job(4, 1, 1000, -1, 10);
      check_val("mid_valid_pre", 64'(first_valid), 64'd8);
      check_val("mid_busy",      64'(rst_busy),     64'd0);
      check_val("mid_valid",     64'(rst_valid),    64'd0);
      check_val("mid_done_n",    64'(done_cnt),     64'd0);
      check_val("mid_busy_end",  64'(busy_end),     64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Sits at the bottom edge of the N-column weight-stationary systolic array.
- Receives the skewed partial-sum stream from the last PE row, where column j lags column j-1 by one cycle.
- Deskews the stream into whole result rows C[i][0..N-1] and buffers them in a FIFO.
- Presents the rows to the downstream consumer over a valid/ready interface. The array cannot stall, so any row that arrives when the FIFO is full is dropped and flagged.

Parameters:
- N, 4, array columns, i.e. elements per result row.
- ACC_WIDTH, 16, signed width of each partial-sum/result element.
- BASE_LAT, 5, cycles from the start edge S until C[0][0] is valid on column 0.
- DEPTH, 4, FIFO depth in rows; power of two, at least 2.
- ROW_W, 8, width of the num_rows counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  pulse; the edge that samples it high is edge S; ignored while busy=1.
- num_rows  in  ROW_W  M, the number of result rows for this job; latched at S.
- col_psum  in  N*ACC_WIDTH  bottom-row outputs; column j occupies bits [j*ACC_WIDTH +: ACC_WIDTH].
- out_valid  out  1  head FIFO row is available.
- out_ready  in  1  consumer accepts the row; a pop happens when out_valid && out_ready.
- out_row  out  N*ACC_WIDTH  deskewed row; same packing as col_psum.
- out_last  out  1  head row is row M-1 of the job.
- busy  out  1  a job is in progress.
- done  out  1  one-cycle pulse at job completion.
- overflow  out  1  sticky; at least one row was dropped in this job.

Behaviour:
- Reset (rst_n=0 at an edge): FSM goes to IDLE; FIFO, deskew lines and counters are cleared. All outputs are 0: out_valid, out_row, out_last, busy, done, overflow. Reset mid-job abandons the job with no done pulse.
- Input timing contract: C[i][j] is on column j of col_psum during the cycle before edge S+BASE_LAT+i+j. Values outside that window are don't-care and must not be captured.
- Deskew: column j passes through an (N-1-j)-stage register line, so column N-1 passes directly. The aligned row i is therefore present at edge W_i = S+BASE_LAT+N-1+i.
- Deskew lines shift every cycle regardless of FSM state.
- Elements are copied bit-exact: no sign extension, truncation or arithmetic.
- FSM:
  - IDLE: busy=0. start=1 with M>0 → WAIT, wait counter loaded with BASE_LAT+N-1, overflow cleared. start=1 with M=0 → stay in IDLE, done=1 in the cycle after S, overflow cleared.
  - WAIT: busy=1; counts down. The transition to CAPTURE is timed so that the first write occurs exactly at edge W_0.
  - CAPTURE: busy=1; one aligned row is written per cycle, edges W_0..W_{M-1}, tagged with last=(i==M-1). After the write of row M-1 → DRAIN.
  - DRAIN: busy=1; when the FIFO is empty → IDLE, with done=1 for the single cycle after the last pop.
- start while busy=1 is ignored and has no side effect.
- FIFO:
  - A write at edge W_i makes the row visible on out_row/out_valid in the following cycle, provided it is the head.
  - out_row and out_last are meaningful only when out_valid=1; they hold their value while out_valid && !out_ready.
- Full boundary:
  - Write when full with no pop at the same edge → row dropped and overflow set to 1. The row counter still advances, so the CAPTURE length is always exactly M cycles.
  - Write when full with a pop at the same edge → the write is accepted.
  - Pop and write at the same edge when not full → both occur and the count is unchanged.
- Empty boundary: out_valid=0. A pop attempt while empty is impossible, because a pop requires out_valid=1.
- A dropped last row means no out_last is ever emitted for the job; done is still generated.
- overflow holds until the next accepted start or reset.
- Pointers are log2(DEPTH) bits wide and wrap naturally. The count is log2(DEPTH)+1 bits.

Test Plan (N=4, ACC_WIDTH=16, BASE_LAT=5, DEPTH=4):
- Reset: hold rst_n=0 for 3 cycles with random inputs → every output is 0. Assert rst_n=0 mid-CAPTURE → busy=0 and out_valid=0 after the edge, with no done pulse.
- Single row: M=1; drive column j=100+j before edge S+5+j and 0xDEAD at all other times → out_valid rises after edge S+8; out_row={103,102,101,100} (column 0 in the LSBs); out_last=1; done pulses the cycle after the pop.
- Streaming: M=3, out_ready=1, C[i][j]=16*i+j → three consecutive rows in order; out_last only on row 2; overflow=0; exactly one done pulse.
- Backpressure/overflow: M=6 with out_ready=0 until edge S+15, then 1 → rows 0-3 delivered; rows 4 and 5 dropped; overflow=1; no out_last; done after the 4th pop. A following start clears overflow.
- Full with simultaneous pop: M=5; out_ready pulses only at the edge of row 4's write → all 5 rows delivered; overflow=0.
- Signed pass-through and control corners:
  - Values 0xFFFF (-1) and 0x8000 (-32768) → emitted unchanged.
  - start during busy → ignored.
  - M=0 → done the cycle after S; out_valid never rises.
